// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto a
// single memory command interface. One access at a time through the FSM
// IDLE -> ISSUE -> WAIT -> DONE. WAIT aborts after TIMEOUT_CYCLES cycles.
//
// Handshake: a port raises req (level) with stable command fields and holds
// it until it sees a one-cycle ack pulse. The memory side sees a one-cycle
// read/write strobe in ISSUE and answers with mem_ready, which the arbiter
// samples only in WAIT.
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration between
// the two ports; leave it undefined for fixed priority, where the data port
// always wins.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_signed,
  input  logic [1:0]  d_width,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        bus_err,
  output logic        busy,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic        mem_signed_read,
  output logic [1:0]  mem_data_width,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ready,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Last WAIT cycle index; the counter starts at 0 on the first WAIT cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        grant_data_q, grant_data_d;
  logic        cmd_we_q, cmd_we_d;
  logic        cmd_signed_q, cmd_signed_d;
  logic [1:0]  cmd_width_q, cmd_width_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        busy_q, busy_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic        pick_data;
`ifdef ARB_ROUND_ROBIN_EN
  // rr_q=1: the data port wins the next tie (fetch was granted last).
  logic        rr_q, rr_d;
`endif

  // Next-state, winner selection and registered-output computation.
  always_comb begin
    state_d      = state_q;
    grant_data_d = grant_data_q;
    cmd_we_d     = cmd_we_q;
    cmd_signed_d = cmd_signed_q;
    cmd_width_d  = cmd_width_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cnt_d        = cnt_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    bus_err_d    = 1'b0;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d         = rr_q;
    pick_data    = d_req && (!if_req || rr_q);
`else
    pick_data    = d_req;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d      = S_ISSUE;
          grant_data_d = pick_data;
`ifdef ARB_ROUND_ROBIN_EN
          rr_d         = !pick_data;
`endif
          if (pick_data) begin
            cmd_we_d     = d_we;
            cmd_signed_d = d_signed;
            cmd_width_d  = d_width;
            cmd_addr_d   = d_addr;
            cmd_wdata_d  = d_wdata;
            rd_en_d      = !d_we;
            wr_en_d      = d_we;
          end else begin
            cmd_we_d     = 1'b0;
            cmd_signed_d = 1'b0;
            cmd_width_d  = 2'd3;
            cmd_addr_d   = if_addr;
            cmd_wdata_d  = 32'd0;
            rd_en_d      = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = 8'd0;
      end
      S_WAIT: begin
        if (mem_ready || (cnt_q == TO_LAST)) begin
          state_d   = S_DONE;
          bus_err_d = !mem_ready;
          if (grant_data_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_ready ? mem_data_out : 32'd0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ready ? mem_data_out : 32'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, command and output registers; reset abandons any access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      grant_data_q <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_signed_q <= 1'b0;
      cmd_width_q  <= 2'd0;
      cmd_addr_q   <= 32'd0;
      cmd_wdata_q  <= 32'd0;
      cnt_q        <= 8'd0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
      bus_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q         <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      cmd_we_q     <= cmd_we_d;
      cmd_signed_q <= cmd_signed_d;
      cmd_width_q  <= cmd_width_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cnt_q        <= cnt_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      bus_err_q    <= bus_err_d;
      busy_q       <= busy_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q         <= rr_d;
`endif
    end
  end

  assign if_ack           = if_ack_q;
  assign d_ack            = d_ack_q;
  assign if_rdata         = if_rdata_q;
  assign d_rdata          = d_rdata_q;
  assign bus_err          = bus_err_q;
  assign busy             = busy_q;
  assign mem_read_enable  = rd_en_q;
  assign mem_write_enable = wr_en_q;
  assign mem_signed_read  = cmd_signed_q;
  assign mem_data_width   = cmd_width_q;
  assign mem_address      = cmd_addr_q;
  assign mem_data_in      = cmd_wdata_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level reference model (grant choice, ack latency, rdata).
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_signed = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_data_out = '0;
  logic [1:0]  d_width = '0;
  logic        mem_ready = 1'b0;
  logic        if_ack, d_ack, bus_err, busy;
  logic        mem_write_enable, mem_read_enable, mem_signed_read;
  logic [1:0]  mem_data_width, dbg_state;
  logic [31:0] if_rdata, d_rdata, mem_address, mem_data_in;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_signed(d_signed), .d_width(d_width),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_err(bus_err), .busy(busy),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_signed_read(mem_signed_read), .mem_data_width(mem_data_width),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready),
    .dbg_state_o(dbg_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        last_data = 1'b0;  // model: most recent grant went to data port
  logic        pend_if = 1'b0, pend_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".if_ack"}, 32'(if_ack), 0);
    check({tag, ".d_ack"}, 32'(d_ack), 0);
    check({tag, ".bus_err"}, 32'(bus_err), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".rd_en"}, 32'(mem_read_enable), 0);
    check({tag, ".wr_en"}, 32'(mem_write_enable), 0);
    check({tag, ".addr"}, mem_address, 0);
    check({tag, ".data_in"}, mem_data_in, 0);
    check({tag, ".width"}, 32'(mem_data_width), 0);
    check({tag, ".signed"}, 32'(mem_signed_read), 0);
    check({tag, ".if_rdata"}, if_rdata, 0);
    check({tag, ".d_rdata"}, d_rdata, 0);
  endtask

  // driver: one arbitrated access; delay = WAIT cycles with mem_ready low
  task automatic txn(input string tag, input logic ir, input logic dr,
                     input int delay, input bit drop_early, input bit keep_win);
    logic        wd, e_we, e_sg, e_err;
    logic [1:0]  e_w;
    logic [31:0] e_addr, e_wdata, e_rd;
    int          ack_k;
    wd      = RR ? ((ir && dr) ? !last_data : dr) : dr;
    last_data = wd;
    e_we    = wd ? d_we : 1'b0;
    e_sg    = wd ? d_signed : 1'b0;
    e_w     = wd ? d_width : 2'd3;
    e_addr  = wd ? d_addr : if_addr;
    e_wdata = wd ? d_wdata : 32'd0;
    e_err   = (delay >= TO);
    ack_k   = e_err ? 2 + TO : 3 + delay;
    exp_q.push_back(e_err ? 32'd0 : mem_data_out);
    if_req  = ir;
    d_req   = dr;
    for (int k = 1; k <= ack_k + 1; k++) begin
      if (k - 1 < 2) mem_ready = 1'($urandom_range(0, 1));
      else           mem_ready = (k - 1 >= 2 + delay);
      @(posedge clk); #1;
      check({tag, ".busy"}, 32'(busy), 32'(k <= ack_k));
      check({tag, ".rd_en"}, 32'(mem_read_enable), 32'(k == 1 && !e_we));
      check({tag, ".wr_en"}, 32'(mem_write_enable), 32'(k == 1 && e_we));
      check({tag, ".if_ack"}, 32'(if_ack), 32'(k == ack_k && !wd));
      check({tag, ".d_ack"}, 32'(d_ack), 32'(k == ack_k && wd));
      if (k == 1 || k == ack_k) begin
        check({tag, ".addr"}, mem_address, e_addr);
        check({tag, ".width"}, 32'(mem_data_width), 32'(e_w));
        check({tag, ".signed"}, 32'(mem_signed_read), 32'(e_sg));
        check({tag, ".data_in"}, mem_data_in, e_wdata);
      end
      if (k == ack_k) begin
        e_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, ".rdata"}, wd ? d_rdata : if_rdata, e_rd);
        check({tag, ".bus_err"}, 32'(bus_err), 32'(e_err));
        if (!keep_win) begin
          if (wd) d_req = 1'b0; else if_req = 1'b0;
        end
      end
      if (k == 1 && drop_early) begin
        if (wd) d_req = 1'b0; else if_req = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    last_data = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic ir, dr;
    // reset state
    do_reset();
    check_zero("reset");
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    check_zero("idle_after_reset");

    // single fetch, ready immediately
    if_addr = 32'h0000_0010; mem_data_out = 32'h00A0_0093;
    txn("fetch_basic", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // byte store with one not-ready WAIT cycle
    d_we = 1'b1; d_width = 2'd0; d_signed = 1'b0;
    d_addr = 32'h0100_0005; d_wdata = 32'h0000_00AB; mem_data_out = 32'h1234_5678;
    txn("store_byte", 1'b0, 1'b1, 1, 1'b0, 1'b0);

    // signed half load dropped after issue still completes
    d_we = 1'b0; d_width = 2'd1; d_signed = 1'b1; d_addr = 32'h0000_2002;
    d_wdata = 32'h5555_AAAA; mem_data_out = 32'hFFFF_8001;
    txn("load_drop", 1'b0, 1'b1, 2, 1'b1, 1'b0);

    // timeout then normal access
    if_addr = 32'h0000_0400; mem_data_out = 32'hCAFE_F00D;
    txn("timeout", 1'b1, 1'b0, 100, 1'b0, 1'b0);
    txn("after_timeout", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    txn("last_ok_wait", 1'b1, 1'b0, TO - 1, 1'b0, 1'b0);

    // both ports held from reset
    do_reset();
    if_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_we = 1'b0;
    d_width = 2'd3; d_signed = 1'b0; mem_data_out = 32'h0BAD_CAFE;
    if_req = 1'b1; d_req = 1'b1;
    #2 reset_n = 1'b1;
    txn("both_1", 1'b1, 1'b1, 0, 1'b0, 1'b1);
    txn("both_2", 1'b1, 1'b1, 0, 1'b0, 1'b1);
    txn("both_3", 1'b1, 1'b1, 0, 1'b0, 1'b0);
    pend_if = if_req; pend_d = d_req;
    if (pend_if || pend_d) txn("both_drain", pend_if, pend_d, 0, 1'b0, 1'b0);

    // randomized traffic; a losing port keeps its request and fields
    pend_if = 1'b0; pend_d = 1'b0;
    repeat (24) begin
      ir = pend_if | 1'($urandom_range(0, 1));
      dr = pend_d | 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1'b1;
      if (!pend_if) if_addr = $urandom;
      if (!pend_d) begin
        d_we = 1'($urandom_range(0, 1));
        d_signed = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0: d_width = 2'd0;
          1: d_width = 2'd1;
          default: d_width = 2'd3;
        endcase
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      mem_data_out = $urandom;
      txn("rand", ir, dr, $urandom_range(0, 5), ($urandom_range(0, 3) == 0), 1'b0);
      pend_if = ir && last_data;
      pend_d  = dr && !last_data;
    end
    if (pend_if || pend_d) txn("rand_drain", pend_if, pend_d, 0, 1'b0, 1'b0);

    // reset during WAIT
    if_addr = 32'h0000_0800; mem_data_out = 32'h7777_0001;
    if_req = 1'b1; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_zero("reset_in_wait");
    if_req = 1'b0;
    last_data = 1'b0;
    exp_q.delete();
    @(posedge clk); #2 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("no_ack_after_reset.if", 32'(if_ack), 0);
      check("no_ack_after_reset.d", 32'(d_ack), 0);
      check("no_ack_after_reset.busy", 32'(busy), 0);
    end
    mem_data_out = 32'h0000_1111;
    txn("fresh_fetch", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max WAIT cycles before an access is aborted (legal 1..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch request, level, held until if_ack.
REQ-005 if_addr  input  32  fetch byte address, stable while if_req=1.
REQ-006 if_ack  output  1  one-cycle completion pulse for fetch port.
REQ-007 if_rdata  output  32  fetched word, valid while if_ack=1.
REQ-008 d_req  input  1  data request, level, held until d_ack.
REQ-009 d_we  input  1  1=store, 0=load.
REQ-010 d_signed  input  1  sign-extend load.
REQ-011 d_width  input  2  0=byte, 1=half, 3=word.
REQ-012 d_addr  input  32  data byte address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_ack  output  1  one-cycle completion pulse for data port.
REQ-015 d_rdata  output  32  load data, valid while d_ack=1.
REQ-016 bus_err  output  1  timeout flag, valid only with if_ack or d_ack.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 mem_write_enable, mem_read_enable, mem_signed_read  output  1 each  memory-side command strobes.
REQ-019 mem_data_width  output  2; mem_address  output  32; mem_data_in  output  32  memory-side command fields.
REQ-020 mem_data_out  input  32; mem_ready  input  1  memory-side response.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, DONE; all outputs registered except the mem_* fields, which are driven from a latched command register.
REQ-022 IDLE: if any request is pending, latch the winner's command and port id and go to ISSUE; otherwise stay in IDLE.
REQ-023 Fetch command: read, width=3, signed=0, wdata=0.
REQ-024 ISSUE, exactly one cycle: mem_read_enable=~we, mem_write_enable=we; next state WAIT; timeout counter cleared.
REQ-025 WAIT: both enables=0; address, width, signed and data_in held; counter increments each cycle.
REQ-026 WAIT exit: when mem_ready=1, sample mem_data_out into the granted port's rdata and go to DONE with bus_err=0.
REQ-027 WAIT abort: if counter reaches TIMEOUT_CYCLES with mem_ready=0, go to DONE with bus_err=1 and rdata=0.
REQ-028 DONE, one cycle: pulse the granted port's ack; then go to IDLE. The ungranted port's ack stays 0.
REQ-029 Minimum latency: req seen in IDLE at cycle N gives ack at cycle N+3 when mem_ready=1 on the first WAIT cycle.
REQ-030 Requests are not re-evaluated before IDLE; a port that drops req mid-transaction still receives its ack.
REQ-031 A req still high in the DONE cycle is a new request in the following IDLE cycle, not a duplicate.

Reset
REQ-032 reset_n=0: state=IDLE; all acks, bus_err, busy and mem enables 0; rdata and command registers 0; round-robin pointer points to the data port.
REQ-033 Reset mid-transaction abandons the access silently; no ack is issued after reset release.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the port not granted most recently wins; the pointer updates on entry to ISSUE.
REQ-035 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, data port always beats fetch port; pointer logic is absent.

Verification
REQ-036 if_req=1, if_addr=0x00000010, mem_ready held 1, mem_data_out=0x00A00093 -> ISSUE one cycle with read, width 3; if_ack at +3 cycles; if_rdata=0x00A00093; bus_err=0.
REQ-037 d_req store, width 0, d_addr=0x01000005, d_wdata=0xAB, mem_ready low 1 cycle in WAIT -> mem_write_enable high only in ISSUE; d_ack at +4 cycles.
REQ-038 if_req and d_req both high from reset, both held; round robin -> grant order data, fetch, data; fixed priority -> data is granted every cycle and fetch never is.
REQ-039 TIMEOUT_CYCLES=4, mem_ready stuck 0 -> ack with bus_err=1 and rdata=0 after 4 WAIT cycles; next request is served normally.
REQ-040 reset_n pulsed low during WAIT -> outputs zero immediately; no ack after release; a fresh if_req completes normally.
